noc_pattern_sender: RTL

Periodically emits single-beat messages onto the NoC through a NAP data-stream transmit interface. Each message carries an 8-bit pattern in `data[7:0]` addressed to a fixed destination NAP. It sits directly upstream of the LED receiver, which displays the low byte it receives. Delivery is visible end-to-end on the board LEDs.

---
 rtl/sender_pkg.sv | 14 +
 rtl/t_DATA_STREAM.sv | 17 +
 rtl/interval_timer.sv | 26 ++
 rtl/noc_pattern_sender.sv | 100 ++++++++++
 4 files changed

// File: rtl/sender_pkg.sv
// Shared types and widths for the NoC pattern sender and its NAP stream interface.
package sender_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } sender_state_t;

    localparam int PATTERN_W  = 8;
    localparam int CNT_W      = 16;
    localparam int NAP_DATA_W = 32;
    localparam int NAP_ADDR_W = 8;

endpackage

// File: rtl/t_DATA_STREAM.sv
// Single-beat NAP data-stream bundle; tx drives the beat, rx returns ready.
interface t_DATA_STREAM
    import sender_pkg::*;
#(
    parameter int DATA_W = NAP_DATA_W,
    parameter int ADDR_W = NAP_ADDR_W
);
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;

    modport tx (output valid, output data, output addr, output sop, output eop, input ready);
    modport rx (input valid, input data, input addr, input sop, input eop, output ready);
endinterface

// File: rtl/interval_timer.sv
// Free-running 0..TICKS-1 counter gated by enable; pulses tick on the last count.
module interval_timer #(
    parameter int TICKS = 25_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick
);
    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/noc_pattern_sender.sv
// Periodic single-beat pattern sender onto a NAP tx stream.
// Optional feature macro: SENDER_OVERRUN_CNT_EN enables the dropped-tick counter.
module noc_pattern_sender
    import sender_pkg::*;
#(
    parameter int TICKS_PER_MSG = 25_000_000,
    parameter int DEST_ID       = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    output logic [CNT_W-1:0] sent_count,
    output logic [CNT_W-1:0] overrun_count,
    t_DATA_STREAM.tx         nap
);
    sender_state_t         state, state_nxt;
    logic [PATTERN_W-1:0]  pattern, pattern_nxt;
    logic [NAP_DATA_W-1:0] data_r, data_nxt;
    logic                  valid_r, valid_nxt;
    logic                  sent_inc;
    logic                  tick;

    interval_timer #(.TICKS(TICKS_PER_MSG)) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .tick   (tick)
    );

    // sop/eop always equal valid for a single-beat message
    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        data_nxt    = data_r;
        valid_nxt   = valid_r;
        sent_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    pattern_nxt = pattern + 1'b1;
                    data_nxt    = NAP_DATA_W'(pattern_nxt);
                    valid_nxt   = 1'b1;
                    state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (valid_r && nap.ready) begin
                    valid_nxt = 1'b0;
                    sent_inc  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            pattern    <= '0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            sent_count <= '0;
        end else begin
            state   <= state_nxt;
            pattern <= pattern_nxt;
            data_r  <= data_nxt;
            valid_r <= valid_nxt;
            if (sent_inc) begin
                sent_count <= sent_count + 1'b1;
            end
        end
    end

`ifdef SENDER_OVERRUN_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A tick that lands while a message is pending is dropped, even on the accept cycle
    logic overrun_inc;
    assign overrun_inc = (state == S_SEND) && tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_count <= '0;
        end else if (overrun_inc) begin
            overrun_count <= sat_inc(overrun_count);
        end
    end
`else
    assign overrun_count = '0;
`endif

    assign nap.valid = valid_r;
    assign nap.sop   = valid_r;
    assign nap.eop   = valid_r;
    assign nap.data  = data_r;
    assign nap.addr  = NAP_ADDR_W'(DEST_ID);
endmodule
